// File: rtl/bit_serializer.sv
// bit_serializer: parallel-to-serial stage feeding a serial sequence detector.
// Accepts W-bit words over a valid/ready handshake and shifts them out one bit
// per falling clock edge on sout. Consecutive words follow each other with no
// idle gap. When no word is pending, sout is held at IDLE_BIT.
module bit_serializer #(
  parameter int W         = 8,
  parameter bit MSB_FIRST = 1'b1,
  parameter bit IDLE_BIT  = 1'b1
) (
  input  logic         ck,
  input  logic         rs,
  input  logic         clr,
  input  logic [W-1:0] din,
  input  logic         din_valid,
  output logic         din_ready,
  output logic         sout,
  output logic         sout_valid,
  output logic         busy,
  output logic [5:0]   bit_cnt,
  output logic [7:0]   word_cnt
);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  localparam logic [5:0] LAST_CNT = 6'(W);

  state_t       state;
  logic [W-1:0] shreg;
  logic         at_last;
  logic         accept;

  // Bit that leaves a word first, according to the configured shift order.
  function automatic logic first_bit(input logic [W-1:0] w);
    return MSB_FIRST ? w[W-1] : w[0];
  endfunction

  // Word with its outgoing bit removed, so the next bit moves into position.
  function automatic logic [W-1:0] drop_bit(input logic [W-1:0] w);
    return MSB_FIRST ? (w << 1) : (w >> 1);
  endfunction

  // The last bit of the current word is on the line during this cycle.
  assign at_last   = (state == SHIFT) && (bit_cnt == LAST_CNT);

  // Ready is combinational so a new word can be taken on the very edge that
  // retires the last bit of the previous one, avoiding a bubble.
  assign din_ready = !clr && ((state == IDLE) || (bit_cnt == LAST_CNT));
  assign accept    = din_valid && din_ready;
  assign busy      = (state == SHIFT);

  // Serializer state: load, shift, retire words, flush on clr.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values; the asynchronous reset clears all of them,
  // including the shift register, so no stale data survives a reset.
  always_ff @(negedge ck or negedge rs) begin
    if (!rs) begin
      state      <= IDLE;
      shreg      <= '0;
      sout       <= IDLE_BIT;
      sout_valid <= 1'b0;
      bit_cnt    <= '0;
      word_cnt   <= '0;
    end else if (clr) begin
      // Flush: a word whose last bit is on the line is not counted.
      state      <= IDLE;
      shreg      <= '0;
      sout       <= IDLE_BIT;
      sout_valid <= 1'b0;
      bit_cnt    <= '0;
    end else begin
      if (at_last) begin
        word_cnt <= word_cnt + 8'd1;
      end

      if (accept) begin
        shreg      <= drop_bit(din);
        sout       <= first_bit(din);
        sout_valid <= 1'b1;
        bit_cnt    <= 6'd1;
        state      <= SHIFT;
      end else if (at_last) begin
        state      <= IDLE;
        shreg      <= '0;
        sout       <= IDLE_BIT;
        sout_valid <= 1'b0;
        bit_cnt    <= '0;
      end else if (state == SHIFT) begin
        sout    <= first_bit(shreg);
        shreg   <= drop_bit(shreg);
        bit_cnt <= bit_cnt + 6'd1;
      end
    end
  end

endmodule

// File: tb/tb_bit_serializer.sv
// Testbench for bit_serializer. Two instances (MSB-first with idle level 1,
// LSB-first with idle level 0) share one stimulus stream. The stimulus side
// pushes each accepted word's bits, in shift order, into per-instance queues;
// a monitor pops one expected bit per data cycle after each falling edge.
module tb_bit_serializer;

  localparam int W = 8;

  logic         ck        = 1'b1;
  logic         rs        = 1'b0;
  logic         clr       = 1'b0;
  logic         din_valid = 1'b0;
  logic [W-1:0] din       = '0;

  logic       rdy_m, sout_m, sv_m, busy_m;
  logic [5:0] bc_m;
  logic [7:0] wc_m;
  logic       rdy_l, sout_l, sv_l, busy_l;
  logic [5:0] bc_l;
  logic [7:0] wc_l;

  bit_serializer #(.W(W), .MSB_FIRST(1'b1), .IDLE_BIT(1'b1)) dut (
    .ck(ck), .rs(rs), .clr(clr), .din(din), .din_valid(din_valid),
    .din_ready(rdy_m), .sout(sout_m), .sout_valid(sv_m), .busy(busy_m),
    .bit_cnt(bc_m), .word_cnt(wc_m)
  );

  bit_serializer #(.W(W), .MSB_FIRST(1'b0), .IDLE_BIT(1'b0)) dut_lsb (
    .ck(ck), .rs(rs), .clr(clr), .din(din), .din_valid(din_valid),
    .din_ready(rdy_l), .sout(sout_l), .sout_valid(sv_l), .busy(busy_l),
    .bit_cnt(bc_l), .word_cnt(wc_l)
  );

  always #5 ck = ~ck;

  int n_vec  = 0;
  int n_miss = 0;

  // Reference model: expected serial bits still to come, bits of the current
  // word already on the line (0 = idle), and words completed.
  bit         q_m[$];
  bit         q_l[$];
  int         m_pos  = 0;
  logic [7:0] m_word = '0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic push_word(input logic [W-1:0] d);
    for (int i = 0; i < W; i++) begin
      q_m.push_back(d[W-1-i]);
      q_l.push_back(d[i]);
    end
  endtask

  // One clock of stimulus: drive inputs between falling edges, check the
  // combinational ready, then advance the model across the coming edge.
  task automatic cycle(input logic v, input logic [W-1:0] d, input logic c,
                       output bit acc);
    bit rdy;
    @(posedge ck);
    din_valid = v;
    din       = d;
    clr       = c;
    #1;
    rdy = !c && (m_pos == 0 || m_pos == W);
    check("din_ready", 32'(rdy_m), 32'(rdy));
    check("din_ready_lsb", 32'(rdy_l), 32'(rdy));
    acc = v && rdy;
    if (c) begin
      m_pos = 0;
      q_m.delete();
      q_l.delete();
    end else begin
      if (m_pos == W) m_word++;
      if (acc) begin
        m_pos = 1;
        push_word(d);
      end else if (m_pos == W) begin
        m_pos = 0;
      end else if (m_pos > 0) begin
        m_pos++;
      end
    end
  endtask

  task automatic idle(input int n);
    bit acc;
    for (int i = 0; i < n; i++) cycle(1'b0, '0, 1'b0, acc);
  endtask

  // Offer a word with din_valid held until it is taken (bounded wait).
  task automatic send(input logic [W-1:0] d);
    bit acc;
    acc = 1'b0;
    for (int i = 0; i < 2 * W + 2 && !acc; i++) cycle(1'b1, d, 1'b0, acc);
    check("send_accepted", 32'(acc), 32'd1);
  endtask

  // Assert reset between edges and confirm outputs clear without a clock.
  task automatic do_reset();
    @(posedge ck);
    din_valid = 1'b0;
    clr       = 1'b0;
    rs        = 1'b0;
    #1;
    check("rst_sout", 32'(sout_m), 32'd1);
    check("rst_sout_lsb", 32'(sout_l), 32'd0);
    check("rst_sout_valid", 32'({sv_m, sv_l}), 32'd0);
    check("rst_busy", 32'({busy_m, busy_l}), 32'd0);
    check("rst_bit_cnt", 32'({bc_m, bc_l}), 32'd0);
    check("rst_word_cnt", 32'({wc_m, wc_l}), 32'd0);
    check("rst_din_ready", 32'({rdy_m, rdy_l}), 32'd3);
    q_m.delete();
    q_l.delete();
    m_pos  = 0;
    m_word = '0;
    @(negedge ck);
    #2;
    rs = 1'b1;
  endtask

  // Monitor: after every falling edge compare registered outputs to the model.
  initial begin
    forever begin
      @(negedge ck);
      #1;
      if (rs) begin
        check("sout_valid", 32'(sv_m), 32'(m_pos != 0));
        check("sout_valid_lsb", 32'(sv_l), 32'(m_pos != 0));
        check("busy", 32'(busy_m), 32'(m_pos != 0));
        check("busy_lsb", 32'(busy_l), 32'(m_pos != 0));
        check("bit_cnt", 32'(bc_m), 32'(m_pos));
        check("bit_cnt_lsb", 32'(bc_l), 32'(m_pos));
        check("word_cnt", 32'(wc_m), 32'(m_word));
        check("word_cnt_lsb", 32'(wc_l), 32'(m_word));
        if (m_pos != 0 && q_m.size() > 0 && q_l.size() > 0) begin
          check("sout_bit", 32'(sout_m), 32'(q_m.pop_front()));
          check("sout_bit_lsb", 32'(sout_l), 32'(q_l.pop_front()));
        end else begin
          check("sout_idle", 32'(sout_m), 32'd1);
          check("sout_idle_lsb", 32'(sout_l), 32'd0);
        end
      end
    end
  end

  initial begin
    bit         acc;
    logic [W-1:0] d;
    logic       v;
    logic       c;

    do_reset();

    // Single word 0x36: MSB-first 00110110, LSB-first 01101100.
    send(8'h36);
    idle(12);
    check("single_word_cnt", 32'(wc_m), 32'd1);

    // Back-to-back 0xF0, 0x0F with din_valid held across the boundary.
    send(8'hF0);
    send(8'h0F);
    idle(12);
    check("b2b_word_cnt", 32'(wc_m), 32'd3);

    // Lone set bit, exercises shift order on both instances.
    send(8'h01);
    idle(10);

    // clr after the 4th bit of 0xAA while din_valid is high.
    send(8'hAA);
    idle(3);
    cycle(1'b1, 8'hAA, 1'b1, acc);
    check("clr_no_accept", 32'(acc), 32'd0);
    cycle(1'b1, 8'hAA, 1'b0, acc);
    check("accept_after_clr", 32'(acc), 32'd1);
    idle(10);
    check("clr_word_cnt", 32'(wc_m), 32'd5);

    // Reset while the 5th bit is on the line, then a clean word afterwards.
    send(8'h5C);
    idle(4);
    do_reset();
    send(8'hC3);
    idle(10);
    check("post_reset_word_cnt", 32'(wc_m), 32'd1);

    // Randomised traffic with occasional clr; source holds words until taken.
    d = 8'($urandom);
    v = 1'b1;
    for (int i = 0; i < 800; i++) begin
      c = ($urandom_range(0, 31) == 0);
      cycle(v, d, c, acc);
      if (acc) begin
        d = 8'($urandom);
        v = ($urandom_range(0, 3) != 0);
      end else if (!v) begin
        v = ($urandom_range(0, 2) == 0);
      end
    end
    idle(10);

    // 256 transfers from reset bring word_cnt back to 0; then idle line.
    do_reset();
    for (int i = 0; i < 256; i++) send(8'($urandom));
    idle(10);
    check("word_cnt_wrap", 32'(wc_m), 32'd0);
    check("word_cnt_wrap_lsb", 32'(wc_l), 32'd0);
    check("idle_busy", 32'({busy_m, busy_l}), 32'd0);
    check("idle_level", 32'({sout_m, sout_l}), 32'd2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
